// File: rtl/cnn_pkg.sv
// Shared constants and state encoding for the CNN image-buffer read path.
package cnn_pkg;
  localparam int IMG_W = 28;
  localparam int K     = 5;
  localparam int OUT_W = IMG_W - K + 1;
  localparam int AW    = $clog2(IMG_W);
  localparam int WIN_W = K * K;

  typedef enum logic [2:0] {IDLE, WAIT_ROW, READ, DRAIN, DONE} rd_state_e;

  // window bit for column c (0 = leftmost), row r (0 = top of band)
  function automatic int win_bit(input int c, input int r);
    return K * c + r;
  endfunction

  // lowest bit of the rightmost column, where a new slice enters
  localparam int NEW_COL_LSB = win_bit(K - 1, 0);
endpackage

// File: rtl/conv_rd_ctrl_if.sv
// Buffer read bus plus window stream towards the conv MAC.
interface conv_rd_ctrl_if;
  logic [cnn_pkg::AW-1:0]    data_rd_addr;
  logic [cnn_pkg::AW-1:0]    conv_row_cnt;
  logic [cnn_pkg::K-1:0]     col_data;
  logic                      row_rdy;
  logic [cnn_pkg::WIN_W-1:0] win_data;
  logic                      win_vld;
  logic [cnn_pkg::AW-1:0]    win_col;
  logic [cnn_pkg::AW-1:0]    win_row;

  modport master (
    output data_rd_addr, conv_row_cnt, win_data, win_vld, win_col, win_row,
    input  col_data, row_rdy
  );
  modport slave (
    input  data_rd_addr, conv_row_cnt, win_data, win_vld, win_col, win_row,
    output col_data, row_rdy
  );
endinterface

// File: rtl/win_shift5x5.sv
// 5x5 window shift register fed one column slice per capture, with the
// column-index / valid stage that tags each completed window.
module win_shift5x5
  import cnn_pkg::*;
(
  input  logic             sclk,
  input  logic             s_rst,
  input  logic             flush,
  input  logic [K-1:0]     col_data,
  input  logic             rd_vld,
  input  logic [AW-1:0]    rd_idx,
  input  logic [AW-1:0]    row_idx,
  output logic [WIN_W-1:0] win_data,
  output logic             win_vld,
  output logic [AW-1:0]    win_col,
  output logic [AW-1:0]    win_row
);
  logic cap, full;

  assign cap  = rd_vld && !flush;
  assign full = rd_idx >= AW'(K - 1);

  // shift left one column per capture; a window is complete once K columns are in
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      win_data <= '0;
      win_vld  <= 1'b0;
      win_col  <= '0;
      win_row  <= '0;
    end else begin
      if (cap) begin
        win_data[NEW_COL_LSB +: K]  <= col_data;
        win_data[NEW_COL_LSB-1:0]   <= win_data[WIN_W-1:K];
      end
      win_vld <= cap && full;
      if (cap && full) begin
        win_col <= rd_idx - AW'(K - 1);
        win_row <= row_idx;
      end
    end
  end
endmodule

// File: rtl/conv_rd_ctrl.sv
// Read sequencer for the binarised image buffer: walks 5-row bands column by
// column, one band per downstream row credit, and streams 5x5 windows.
// Optional build macro CONV_RD_CTRL_PERF_EN adds the stall_cnt output.
module conv_rd_ctrl
  import cnn_pkg::*;
(
  input  logic sclk,
  input  logic s_rst,
  input  logic cal_start,
  input  logic abort,
  conv_rd_ctrl_if.master bus,
  output logic frame_done,
  output logic busy,
  output logic overrun
`ifdef CONV_RD_CTRL_PERF_EN
  ,
  output logic [15:0] stall_cnt
`endif
);
  rd_state_e state, state_nxt;
  logic [AW-1:0] addr, row;
  logic          rd_vld;
  logic [AW-1:0] rd_idx;

  assign busy             = state != IDLE;
  assign bus.data_rd_addr = addr;
  assign bus.conv_row_cnt = row;

  // state register
  always_ff @(posedge sclk) begin
    if (s_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state: abort wins over everything, including cal_start
  always_comb begin
    state_nxt = state;
    if (abort) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:     if (cal_start) state_nxt = WAIT_ROW;
        WAIT_ROW: if (bus.row_rdy) state_nxt = READ;
        READ:     if (addr == AW'(IMG_W - 1)) state_nxt = DRAIN;
        DRAIN:    state_nxt = (row == AW'(OUT_W - 1)) ? DONE : WAIT_ROW;
        DONE:     state_nxt = IDLE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  // column address and band row; row must not move until the last slice is back
  always_ff @(posedge sclk) begin
    if (s_rst || abort) begin
      addr <= '0;
      row  <= '0;
    end else begin
      if (state == IDLE && cal_start) row <= '0;
      else if (state == DRAIN && row != AW'(OUT_W - 1)) row <= row + 1'b1;
      if (state == DRAIN) addr <= '0;
      else if (state == READ && addr != AW'(IMG_W - 1)) addr <= addr + 1'b1;
    end
  end

  // capture tag aligned with the buffer's one-cycle read latency
  always_ff @(posedge sclk) begin
    if (s_rst || abort) begin
      rd_vld <= 1'b0;
      rd_idx <= '0;
    end else begin
      rd_vld <= state == READ;
      rd_idx <= addr;
    end
  end

  // frame completion pulse and sticky overrun flag
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= state == DONE && !abort;
      if (cal_start && busy) overrun <= 1'b1;
    end
  end

`ifdef CONV_RD_CTRL_PERF_EN
  // saturating count of cycles spent waiting for a row credit
  always_ff @(posedge sclk) begin
    if (s_rst) stall_cnt <= '0;
    else if (state == IDLE && cal_start && !abort) stall_cnt <= '0;
    else if (state == WAIT_ROW && !bus.row_rdy && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

  win_shift5x5 u_win (
    .sclk     (sclk),
    .s_rst    (s_rst),
    .flush    (abort),
    .col_data (bus.col_data),
    .rd_vld   (rd_vld),
    .rd_idx   (rd_idx),
    .row_idx  (row),
    .win_data (bus.win_data),
    .win_vld  (bus.win_vld),
    .win_col  (bus.win_col),
    .win_row  (bus.win_row)
  );
endmodule

// File: tb/tb_conv_rd_ctrl.sv
// Scoreboard bench for conv_rd_ctrl: image buffer model, frame-level reference
// for window contents and timing, monitor popping expectations on win_vld.
module tb_conv_rd_ctrl;
  logic sclk = 1'b0;
  logic s_rst = 1'b1;
  logic cal_start = 1'b0;
  logic abort = 1'b0;
  logic frame_done, busy, overrun;
`ifdef CONV_RD_CTRL_PERF_EN
  logic [15:0] stall_cnt;
`endif

  conv_rd_ctrl_if bus();

  conv_rd_ctrl dut (
    .sclk       (sclk),
    .s_rst      (s_rst),
    .cal_start  (cal_start),
    .abort      (abort),
    .bus        (bus),
    .frame_done (frame_done),
    .busy       (busy),
    .overrun    (overrun)
`ifdef CONV_RD_CTRL_PERF_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 sclk = ~sclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge sclk) cyc <= cyc + 1;

  // image: img[y][x], y = row, x = column
  logic [27:0] img [0:27];
  logic [4:0]  addr_q;

  // buffer: registered column address, row band selected combinationally
  always @(posedge sclk) addr_q <= bus.data_rd_addr;
  always_comb begin
    bus.col_data = '0;
    for (int r = 0; r < 5; r++)
      if (int'(bus.conv_row_cnt) + r < 28 && addr_q < 5'd28)
        bus.col_data[r] = img[int'(bus.conv_row_cnt) + r][addr_q];
  end

  typedef struct {
    int          cyc;
    int          row;
    int          col;
    logic [24:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];

  function automatic logic [24:0] exp_win(input int y, input int x);
    logic [24:0] w;
    w = '0;
    for (int c = 0; c < 5; c++)
      for (int r = 0; r < 5; r++)
        w[5*c + r] = img[y + r][x + c];
    return w;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // monitor: every presented window / frame_done is matched against the queues
  always @(negedge sclk) begin
    exp_t e;
    if (bus.win_vld) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL win_extra got row=%0d col=%0d at cyc %0d want none",
                 bus.win_row, bus.win_col, cyc);
      end else begin
        e = exp_q.pop_front();
        if (int'(bus.win_row) != e.row || int'(bus.win_col) != e.col ||
            bus.win_data != e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL win got row=%0d col=%0d data=%h cyc=%0d want row=%0d col=%0d data=%h cyc=%0d",
                   bus.win_row, bus.win_col, bus.win_data, cyc, e.row, e.col, e.data, e.cyc);
        end
      end
    end
    if (frame_done) begin
      checks++;
      if (done_q.size() == 0) begin
        errors++;
        $display("FAIL frame_done_extra got pulse at cyc %0d want none", cyc);
      end else if (done_q[0] != cyc) begin
        errors++;
        $display("FAIL frame_done_cyc got %0d want %0d", cyc, done_q[0]);
        void'(done_q.pop_front());
      end else void'(done_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_addr"},    int'(bus.data_rd_addr), 0);
    chk({tag, "_row"},     int'(bus.conv_row_cnt), 0);
    chk({tag, "_win_data"}, int'(bus.win_data), 0);
    chk({tag, "_win_vld"}, int'(bus.win_vld), 0);
    chk({tag, "_win_col"}, int'(bus.win_col), 0);
    chk({tag, "_win_row"}, int'(bus.win_row), 0);
    chk({tag, "_done"},    int'(frame_done), 0);
    chk({tag, "_busy"},    int'(busy), 0);
    chk({tag, "_overrun"}, int'(overrun), 0);
`ifdef CONV_RD_CTRL_PERF_EN
    chk({tag, "_stall"},   int'(stall_cnt), 0);
`endif
  endtask

  // One frame. Row y's WAIT_ROW starts at t[y] cycles after cal_start is taken,
  // lasts 1+s[y] cycles, then 28 reads and 1 drain: 30+s[y] cycles per row.
  task automatic run_frame(input bit rnd, input int stall_row, input int stall_len,
                           input int ovr_at, input int abort_at, input int rst_at);
    int   s[24];
    int   t[24];
    int   tot, start, c_end, quiet;
    bit   cut;
    exp_t e;
    tot = 0;
    cut = 1'b0;
    for (int y = 0; y < 24; y++) begin
      s[y] = (y == stall_row) ? stall_len : (rnd ? int'($urandom_range(0, 3)) : 0);
      t[y] = (y == 0) ? 0 : t[y-1] + s[y-1] + 30;
      tot += s[y];
    end
    start = cyc + 1;
    for (int y = 0; y < 24; y++)
      for (int x = 0; x < 24; x++) begin
        e.cyc  = start + t[y] + s[y] + 7 + x;
        e.row  = y;
        e.col  = x;
        e.data = exp_win(y, x);
        exp_q.push_back(e);
      end
    done_q.push_back(start + 721 + tot);
    cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    c_end = 721 + tot + 2;
    for (int c = 0; c <= c_end; c++) begin
      bus.row_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int y = 0; y < 24; y++) begin
        if (c >= t[y] && c < t[y] + s[y]) begin
          bus.row_rdy = 1'b0;
          if (y == stall_row) begin
            chk("stall_addr", int'(bus.data_rd_addr), 0);
            chk("stall_row", int'(bus.conv_row_cnt), y);
          end
        end else if (c == t[y] + s[y]) bus.row_rdy = 1'b1;
      end
      cal_start = (c == ovr_at);
      abort     = (c == abort_at);
      s_rst     = (c == rst_at);
      tick();
      cal_start = 1'b0;
      if (c == abort_at) begin
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_win_vld", int'(bus.win_vld), 0);
        chk("abort_addr", int'(bus.data_rd_addr), 0);
        chk("abort_row", int'(bus.conv_row_cnt), 0);
        exp_q.delete();
        done_q.delete();
        quiet = 0;
        for (int i = 0; i < 30; i++) begin
          tick();
          quiet += int'(frame_done) + int'(bus.win_vld) + int'(busy);
        end
        chk("abort_quiet", quiet, 0);
        cut = 1'b1;
        break;
      end
      if (c == rst_at) begin
        s_rst = 1'b0;
        chk_zero_outputs("rst_mid");
        exp_q.delete();
        done_q.delete();
        cut = 1'b1;
        break;
      end
    end
    bus.row_rdy = 1'b1;
    if (!cut) begin
      chk("win_left", exp_q.size(), 0);
      chk("done_left", done_q.size(), 0);
      chk("idle_busy", int'(busy), 0);
`ifdef CONV_RD_CTRL_PERF_EN
      chk("stall_cnt", int'(stall_cnt), tot);
`endif
    end
  endtask

  initial begin
    bus.row_rdy = 1'b1;
    for (int y = 0; y < 28; y++) img[y] = '0;
    repeat (3) tick();
    s_rst = 1'b0;
    chk_zero_outputs("reset");
    tick();

    // checkerboard, row_rdy tied high
    for (int y = 0; y < 28; y++)
      for (int x = 0; x < 28; x++) img[y][x] = 1'((x + y) & 1);
    run_frame(1'b0, -1, 0, -1, -1, -1);
    repeat (3) tick();

    // 10-cycle credit stall before row 5
    for (int y = 0; y < 28; y++) img[y] = 28'($urandom);
    run_frame(1'b0, 5, 10, -1, -1, -1);
    repeat (2) tick();

    // single pixel at the bottom-right corner
    for (int y = 0; y < 28; y++) img[y] = '0;
    img[27][27] = 1'b1;
    run_frame(1'b0, -1, 0, -1, -1, -1);
    chk("pre_overrun", int'(overrun), 0);
    repeat (2) tick();

    // cal_start while busy
    for (int y = 0; y < 28; y++) img[y] = 28'($urandom);
    run_frame(1'b0, -1, 0, 100, -1, -1);
    chk("overrun_set", int'(overrun), 1);
    repeat (2) tick();

    // abort, then a full randomised frame
    for (int y = 0; y < 28; y++) img[y] = 28'($urandom);
    run_frame(1'b0, -1, 0, -1, 300, -1);
    for (int y = 0; y < 28; y++) img[y] = 28'($urandom);
    run_frame(1'b1, -1, 0, -1, -1, -1);
    chk("overrun_sticky", int'(overrun), 1);
    repeat (2) tick();

    // reset during row 10, then recover
    for (int y = 0; y < 28; y++) img[y] = 28'($urandom);
    run_frame(1'b1, -1, 0, -1, -1, 310);
    repeat (2) tick();
    for (int y = 0; y < 28; y++) img[y] = 28'($urandom);
    run_frame(1'b1, 7, 4, -1, -1, -1);
    chk("overrun_after_rst", int'(overrun), 0);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_rd_ctrl.md
Name: conv_rd_ctrl

Overview:
- Read sequencer for the binarised 28x28 image buffer in the CNN digit-recognition datapath.
- Starts on the buffer's one-cycle `cal_start` pulse and drives the buffer's `data_rd_addr` and `conv_row_cnt`.
- Captures the returned 5-bit column slices `col_data` into a 5x5 window shift register.
- Emits one 25-bit window per output pixel (24x24 per frame) to the conv MAC, one output row at a time, gated by a downstream row-credit input.

Parameters:
IMG_W, 28, image width/height in pixels; buffer depth and row-bank count
K, 5, kernel size; also the `col_data` width
OUT_W, IMG_W-K+1 (24), output width/height; localparam, not overridable

Ports:
sclk  in  1  system clock
s_rst  in  1  synchronous reset, active-high
cal_start  in  1  1-cycle pulse: image buffer fully written
row_rdy  in  1  downstream can accept a full row of OUT_W windows
abort  in  1  synchronous abort of the current frame
data_rd_addr  out  5  buffer read column address
conv_row_cnt  out  5  top image row of the current 5-row band
col_data  in  K  5 vertical pixels (rows conv_row_cnt..+4) at the column addressed one cycle earlier
win_data  out  K*K  window; bits [5c+4:5c] = column c (c=0 leftmost), bit 5c+r = row r
win_vld  out  1  win_data valid, one cycle
win_col  out  5  output column 0..23 of win_data
win_row  out  5  output row 0..23 of win_data
frame_done  out  1  1-cycle pulse after the last window
busy  out  1  high whenever state != IDLE
overrun  out  1  sticky: cal_start received while busy

Behaviour:
- Reset (s_rst=1 at a sclk edge): all outputs 0; state IDLE; window register 0. `overrun` is cleared only by reset.
- State IDLE:
  - `cal_start` -> WAIT_ROW, with `conv_row_cnt`=0.
- State WAIT_ROW:
  - `row_rdy`=1 -> READ with `data_rd_addr`=0; otherwise hold.
- State READ:
  - `data_rd_addr` increments 0..27, one per cycle.
  - At address 27 -> DRAIN.
  - `conv_row_cnt` stays constant from the first read through DRAIN, because the buffer's column-slice selection depends on it combinationally.
- State DRAIN (1 cycle):
  - Consumes the final returned column.
  - If `conv_row_cnt`=23 -> DONE; otherwise increment `conv_row_cnt` and -> WAIT_ROW.
- State DONE (1 cycle):
  - `frame_done`=1, then -> IDLE.
- Read latency is 1 cycle. Capture flag `rd_vld` = registered (state==READ); captured column index = registered `data_rd_addr`.
- On each `rd_vld` cycle the window shifts left by one column: the new `col_data` enters column 4 and column 0 is dropped.
- `win_vld` is registered one cycle after a capture whose column index >= 4. Then `win_col` = index-4 and `win_row` = `conv_row_cnt`.
  - This gives exactly 24 windows per row and 576 per frame.
- The window register is not cleared between rows; the first 4 captures of a row refill it.
- Timing with `row_rdy` tied high:
  - Each row is 28 READ + 1 DRAIN + 1 WAIT_ROW = 30 cycles.
  - First `win_vld` occurs 7 cycles after `cal_start`.
  - `frame_done` occurs 721 cycles after `cal_start`.
- `cal_start` while busy: ignored, `overrun` set; the frame in progress is unaffected.
- `abort`=1 in any state:
  - Next cycle: IDLE, `win_vld`=0, no `frame_done`.
  - `conv_row_cnt` and `data_rd_addr` return to 0.
  - `abort` has priority over `cal_start` in the same cycle.
- `row_rdy` is sampled only in WAIT_ROW; dropping it mid-row does not stall the row.

Optional Feature:
- Macro: CONV_RD_CTRL_PERF_EN.
- Defined:
  - Adds output `stall_cnt` [15:0], cleared on `cal_start` accepted in IDLE.
  - `stall_cnt` increments each cycle in WAIT_ROW with `row_rdy`=0 and saturates at 16'hFFFF.
  - It holds its value after `frame_done`.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package `cnn_pkg`:
  - IMG_W, K, OUT_W.
  - State enum: IDLE, WAIT_ROW, READ, DRAIN, DONE.
  - Window bit-index helper constant.
- One sub-module, `win_shift5x5`: the shift register plus column-index/valid pipeline (inputs `col_data`, `rd_vld`, index; outputs window, `win_vld`, `win_col`).
- The FSM and address counters stay in the top level.

Test Plan:
- Checkerboard image, `row_rdy`=1, `cal_start` pulse -> 576 `win_vld` pulses, `win_row`/`win_col` raster 0..23; window (0,0) = 25'h0AAAAAA pattern per bit map; `frame_done` exactly 721 cycles after `cal_start`.
- `row_rdy` low for 10 cycles before row 5 -> `data_rd_addr` holds 0 in WAIT_ROW; `conv_row_cnt`=5 unchanged; total frame 731 cycles; with PERF_EN, `stall_cnt`=10.
- Single pixel set at (27,27) -> only window (23,23) is non-zero, bit 24 set.
- `cal_start` reasserted at cycle 100 of a frame -> `overrun`=1; window count still 576; `frame_done` still at 721.
- `abort` at cycle 300 -> next cycle `busy`=0, `win_vld`=0, no `frame_done`; a new `cal_start` yields a full correct frame.
- `s_rst` asserted mid-row 10 -> all outputs 0 on the next edge; `overrun` cleared.
